// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with latency-aligned sync/DE/RGB
// and a downscaled sub-window request port for low-resolution pixel sources.
//
// Ports:
//   vga_clk, sys_rst        pixel clock, synchronous active-high reset
//   pix_data                pixel returned PIPE_LAT clocks after its request
//   pix_req, pix_x, pix_y   request-stage active flag and coordinates
//   win_req, win_x, win_y   request-stage scaled window flag and coordinates
//   frame_start, line_start request-stage pulses at (0,0) and at hcnt==0
//   hsync, vsync, de, rgb   registered monitor outputs, aligned to pix_data

module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int PIX_W       = 16,
  parameter int PIPE_LAT    = 2,
  parameter int SCALE_SHIFT = 2,
  parameter int WIN_W       = 160,
  parameter int WIN_H       = 120
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_req,
  output logic [10:0]      pix_x,
  output logic [10:0]      pix_y,
  output logic             win_req,
  output logic [7:0]       win_x,
  output logic [7:0]       win_y,
  output logic             frame_start,
  output logic             line_start,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT
                         + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT
                         + V_SYNC + V_BACK;

  // Compares run at 12 bits so a 2048 total or
  // an oversized window never wraps a constant.
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_DISPLAY);
  localparam logic [11:0] V_ACT  = 12'(V_DISPLAY);
  localparam logic [11:0] HS_BEG = 12'(H_DISPLAY + H_FRONT);
  localparam logic [11:0] HS_END = 12'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_DISPLAY + V_FRONT);
  localparam logic [11:0] VS_END = 12'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [11:0] WIN_XL = 12'(WIN_W << SCALE_SHIFT);
  localparam logic [11:0] WIN_YL = 12'(WIN_H << SCALE_SHIFT);

  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
        H_DISPLAY < 1 || V_DISPLAY < 1 ||
        H_FRONT < 0 || H_SYNC < 0 || H_BACK < 0 ||
        V_FRONT < 0 || V_SYNC < 0 || V_BACK < 0 ||
        PIPE_LAT < 0 || PIPE_LAT > 7 ||
        SCALE_SHIFT < 0 || SCALE_SHIFT > 3 ||
        WIN_W < 1 || WIN_W > 256 ||
        WIN_H < 1 || WIN_H > 256 ||
        PIX_W < 1) begin : g_bad_param
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } tap_t;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [11:0] h_ext, v_ext;

  assign h_ext = {1'b0, hcnt_q};
  assign v_ext = {1'b0, vcnt_q};

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (h_ext == H_LAST) begin
      hcnt_d = '0;
      if (v_ext == V_LAST) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end
    if (sys_rst) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    hcnt_q <= hcnt_d;
    vcnt_q <= vcnt_d;
  end

  // Request stage: purely combinational
  // from the raster counters.
  logic active;
  logic in_win;
  tap_t raw;

  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign in_win = active && (h_ext < WIN_XL)
                         && (v_ext < WIN_YL);

  assign pix_req     = active;
  assign pix_x       = active ? hcnt_q : 11'h7FF;
  assign pix_y       = active ? vcnt_q : 11'h7FF;
  assign win_req     = in_win;
  assign win_x       = in_win ? 8'(hcnt_q >> SCALE_SHIFT) : 8'd0;
  assign win_y       = in_win ? 8'(vcnt_q >> SCALE_SHIFT) : 8'd0;
  assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);
  assign line_start  = (hcnt_q == '0);

  // Raw taps are active-high; polarity is
  // applied only at the output register.
  assign raw.hs = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign raw.vs = (v_ext >= VS_BEG) && (v_ext < VS_END);
  assign raw.de = active;

  tap_t dly;

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign dly = raw;
    end else begin : g_pipe
      tap_t sr_q [PIPE_LAT];
      tap_t sr_d [PIPE_LAT];

      always_comb begin
        sr_d[0] = raw;
        for (int i = 1; i < PIPE_LAT; i++) begin
          sr_d[i] = sr_q[i-1];
        end
        if (sys_rst) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            sr_d[i] = '0;
          end
        end
      end

      always_ff @(posedge vga_clk) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
          sr_q[i] <= sr_d[i];
        end
      end

      assign dly = sr_q[PIPE_LAT-1];
    end
  endgenerate

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;

  // dly arrives in the same cycle as the
  // pix_data answering that request.
  always_comb begin
    hsync_d = dly.hs ? HS_ACT : ~HS_ACT;
    vsync_d = dly.vs ? VS_ACT : ~VS_ACT;
    de_d    = dly.de;
    rgb_d   = dly.de ? pix_data : '0;
    if (sys_rst) begin
      hsync_d = ~HS_ACT;
      vsync_d = ~VS_ACT;
      de_d    = 1'b0;
      rgb_d   = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    hsync_q <= hsync_d;
    vsync_q <= vsync_d;
    de_q    <= de_d;
    rgb_q   <= rgb_d;
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen across four
// parameter sets (latency, polarity, window scale and clipping).

module tb_vga_timing_gen;

  localparam int NCFG = 4;

  localparam int HD = 40;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 5;
  localparam int VD = 20;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam int C_LAT [NCFG] = '{2, 0, 3, 7};
  localparam int C_SH  [NCFG] = '{2, 0, 1, 2};
  localparam int C_WW  [NCFG] = '{10, 30, 8, 12};
  localparam int C_WH  [NCFG] = '{5, 15, 6, 8};
  localparam int C_HP  [NCFG] = '{0, 1, 0, 0};
  localparam int C_VP  [NCFG] = '{0, 1, 0, 0};

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } out_e;

  typedef struct {
    int          due;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        wreq;
    logic [7:0]  wx;
    logic [7:0]  wy;
    logic        fs;
    logic        ls;
  } req_e;

  out_e        oq  [NCFG][$];
  req_e        rq  [NCFG][$];
  logic [15:0] src [NCFG][$];

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] pix_data [NCFG];

  logic        req_o [NCFG];
  logic [10:0] px_o  [NCFG];
  logic [10:0] py_o  [NCFG];
  logic        wreq_o[NCFG];
  logic [7:0]  wx_o  [NCFG];
  logic [7:0]  wy_o  [NCFG];
  logic        fs_o  [NCFG];
  logic        ls_o  [NCFG];
  logic        hs_o  [NCFG];
  logic        vs_o  [NCFG];
  logic        de_o  [NCFG];
  logic [15:0] rgb_o [NCFG];

  always #5 vga_clk = ~vga_clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    vga_timing_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF),
      .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF),
      .V_SYNC(VS), .V_BACK(VB),
      .HS_POL(C_HP[g]), .VS_POL(C_VP[g]),
      .PIX_W(16), .PIPE_LAT(C_LAT[g]),
      .SCALE_SHIFT(C_SH[g]),
      .WIN_W(C_WW[g]), .WIN_H(C_WH[g])
    ) u_dut (
      .vga_clk    (vga_clk),
      .sys_rst    (sys_rst),
      .pix_data   (pix_data[g]),
      .pix_req    (req_o[g]),
      .pix_x      (px_o[g]),
      .pix_y      (py_o[g]),
      .win_req    (wreq_o[g]),
      .win_x      (wx_o[g]),
      .win_y      (wy_o[g]),
      .frame_start(fs_o[g]),
      .line_start (ls_o[g]),
      .hsync      (hs_o[g]),
      .vsync      (vs_o[g]),
      .de         (de_o[g]),
      .rgb        (rgb_o[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  int m_cyc  = 0;

  task automatic chk(input string nm, input int c,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d got %0h want %0h",
               nm, c, m_cyc, act, exp);
    end
  endtask

  // ---------------- stimulus + reference model
  int g_cyc = 0;
  int n     = 0;

  task automatic step(input bit rst);
    bit was_rst;
    int pos, x, y, sc;
    bit act, win, hs_on, vs_on;
    logic [15:0] v;
    req_e r;
    out_e o;
    @(posedge vga_clk);
    #1;
    g_cyc++;
    was_rst = sys_rst;
    sys_rst = rst;
    if (was_rst) n = 0;
    else n++;
    for (int c = 0; c < NCFG; c++) begin
      if (was_rst) begin
        oq[c].delete();
        rq[c].delete();
        src[c].delete();
        if (!rst) begin
          for (int k = 0; k <= C_LAT[c]; k++) begin
            o.due = g_cyc + k;
            o.hs  = (C_HP[c] == 0);
            o.vs  = (C_VP[c] == 0);
            o.de  = 1'b0;
            o.rgb = '0;
            oq[c].push_back(o);
          end
        end
      end
      if (!rst) begin
        pos   = n % FT;
        x     = pos % HT;
        y     = pos / HT;
        sc    = 1 << C_SH[c];
        act   = (x < HD) && (y < VD);
        win   = act && (x < C_WW[c] * sc)
                    && (y < C_WH[c] * sc);
        hs_on = (x >= HD + HF) && (x < HD + HF + HS);
        vs_on = (y >= VD + VF) && (y < VD + VF + VS);
        v     = 16'($urandom);
        r.due  = g_cyc;
        r.req  = act;
        r.x    = act ? 11'(x) : 11'h7FF;
        r.y    = act ? 11'(y) : 11'h7FF;
        r.wreq = win;
        r.wx   = win ? 8'(x / sc) : 8'd0;
        r.wy   = win ? 8'(y / sc) : 8'd0;
        r.fs   = (pos == 0);
        r.ls   = (x == 0);
        rq[c].push_back(r);
        o.due = g_cyc + C_LAT[c] + 1;
        o.hs  = hs_on ? (C_HP[c] != 0) : (C_HP[c] == 0);
        o.vs  = vs_on ? (C_VP[c] != 0) : (C_VP[c] == 0);
        o.de  = act;
        o.rgb = act ? v : 16'd0;
        oq[c].push_back(o);
        src[c].push_back(v);
        if (src[c].size() == C_LAT[c] + 1) begin
          pix_data[c] = src[c].pop_front();
        end
      end
    end
  endtask

  initial begin
    int k, rl;
    for (int c = 0; c < NCFG; c++) pix_data[c] = '0;
    repeat (3) step(1'b1);
    repeat (2 * FT + 20) step(1'b0);
    // one-clock reset while in vsync, back porch
    while (((n + 1) % FT) != (VD + VF) * HT + 50) begin
      step(1'b0);
    end
    step(1'b1);
    repeat (2 * FT + 10) step(1'b0);
    repeat (2) begin
      k  = $urandom_range(1, FT - 1);
      rl = $urandom_range(1, 3);
      repeat (k) step(1'b0);
      repeat (rl) step(1'b1);
      repeat (FT + FT / 2) step(1'b0);
    end
    @(negedge vga_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // ---------------- monitor
  int   last_fs  [NCFG];
  bit   fs_valid [NCFG];
  bit   rise_pend[NCFG];
  int   rise_base[NCFG];
  int   de_run   [NCFG];
  int   hs_run   [NCFG];
  int   vs_run   [NCFG];
  logic de_prev  [NCFG];

  always @(negedge vga_clk) begin
    req_e r;
    out_e o;
    bit   hs_a, vs_a;
    m_cyc++;
    for (int c = 0; c < NCFG; c++) begin
      if (sys_rst) begin
        fs_valid[c]  = 1'b0;
        rise_pend[c] = 1'b0;
        de_run[c]    = 0;
        hs_run[c]    = 0;
        vs_run[c]    = 0;
        de_prev[c]   = 1'b0;
      end else begin
        chk("req_due", c,
            (rq[c].size() > 0) ? rq[c][0].due : -1, m_cyc);
        if (rq[c].size() > 0) begin
          r = rq[c].pop_front();
          chk("pix_req", c, 32'(req_o[c]), 32'(r.req));
          chk("pix_x", c, 32'(px_o[c]), 32'(r.x));
          chk("pix_y", c, 32'(py_o[c]), 32'(r.y));
          chk("win_req", c, 32'(wreq_o[c]), 32'(r.wreq));
          chk("win_x", c, 32'(wx_o[c]), 32'(r.wx));
          chk("win_y", c, 32'(wy_o[c]), 32'(r.wy));
          chk("frame_start", c, 32'(fs_o[c]), 32'(r.fs));
          chk("line_start", c, 32'(ls_o[c]), 32'(r.ls));
        end
        chk("out_due", c,
            (oq[c].size() > 0) ? oq[c][0].due : -1, m_cyc);
        if (oq[c].size() > 0) begin
          o = oq[c].pop_front();
          chk("hsync", c, 32'(hs_o[c]), 32'(o.hs));
          chk("vsync", c, 32'(vs_o[c]), 32'(o.vs));
          chk("de", c, 32'(de_o[c]), 32'(o.de));
          chk("rgb", c, 32'(rgb_o[c]), 32'(o.rgb));
        end
        if (fs_o[c] === 1'b1) begin
          if (fs_valid[c]) begin
            chk("frame_period", c, m_cyc - last_fs[c], FT);
          end
          last_fs[c]   = m_cyc;
          fs_valid[c]  = 1'b1;
          rise_pend[c] = 1'b1;
          rise_base[c] = m_cyc;
        end
        if (de_o[c] === 1'b1 && de_prev[c] !== 1'b1 &&
            rise_pend[c]) begin
          chk("de_rise_lat", c, m_cyc - rise_base[c],
              C_LAT[c] + 1);
          rise_pend[c] = 1'b0;
        end
        if (de_o[c] === 1'b1) begin
          de_run[c]++;
        end else if (de_run[c] > 0) begin
          chk("de_run", c, de_run[c], HD);
          de_run[c] = 0;
        end
        hs_a = (hs_o[c] === ((C_HP[c] != 0) ? 1'b1 : 1'b0));
        vs_a = (vs_o[c] === ((C_VP[c] != 0) ? 1'b1 : 1'b0));
        if (hs_a) begin
          hs_run[c]++;
        end else if (hs_run[c] > 0) begin
          chk("hs_width", c, hs_run[c], HS);
          hs_run[c] = 0;
        end
        if (vs_a) begin
          vs_run[c]++;
        end else if (vs_run[c] > 0) begin
          chk("vs_width", c, vs_run[c], VS * HT);
          vs_run[c] = 0;
        end
        de_prev[c] = de_o[c];
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with pixel-fetch latency compensation and a scaled sub-window port. It drives the monitor sync/DE/RGB pins and issues pixel coordinates to the upstream pixel source (game renderer or framebuffer). Sync and data-enable outputs are delayed to line up with pixel data that returns a fixed number of cycles after the request. A downscaled window (for example 160x120 shown at 4x) is decoded on the request side so low-resolution framebuffers need no external address arithmetic.

## Interface
Parameters:
- H_DISPLAY, 640: active pixels per line
- H_FRONT, 16: horizontal front porch (clocks)
- H_SYNC, 96: horizontal sync width
- H_BACK, 48: horizontal back porch
- V_DISPLAY, 480: active lines
- V_FRONT, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width
- V_BACK, 33: vertical back porch
- HS_POL, 0: hsync active level
- VS_POL, 0: vsync active level
- PIX_W, 16: pixel data width (RGB565 by default)
- PIPE_LAT, 2: pixel-source read latency in clocks; legal range 0..7
- SCALE_SHIFT, 2: window upscale factor = 2^SCALE_SHIFT; legal range 0..3
- WIN_W, 160: window width in source pixels
- WIN_H, 120: window height in source pixels

Ports:
- vga_clk  in  1  pixel clock (25 MHz at default timing)
- sys_rst  in  1  reset; one clock; reset is synchronous and active-high
- pix_data  in  PIX_W  pixel returned by the source, PIPE_LAT clocks after the matching request
- pix_req  out  1  request stage: current counter position is in the active area
- pix_x  out  11  request X = hcnt when pix_req is high, else 11'h7FF
- pix_y  out  11  request Y = vcnt when pix_req is high, else 11'h7FF
- win_req  out  1  request position lies inside the scaled window
- win_x  out  8  hcnt >> SCALE_SHIFT when win_req is high, else 0
- win_y  out  8  vcnt >> SCALE_SHIFT when win_req is high, else 0
- frame_start  out  1  one-clock pulse at request position (0,0)
- line_start  out  1  one-clock pulse at hcnt==0 on every line 0..V_TOTAL-1
- hsync  out  1  registered, latency-aligned horizontal sync
- vsync  out  1  registered, latency-aligned vertical sync
- de  out  1  registered, latency-aligned data enable
- rgb  out  PIX_W  registered pixel: pix_data when the aligned DE is high, else 0

## Operation
- H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK; V_TOTAL is the vertical equivalent. Default totals are 800 and 525.
- hcnt runs 0..H_TOTAL-1 and wraps to 0.
- vcnt increments when hcnt wraps. When vcnt is at V_TOTAL-1 and hcnt wraps, vcnt returns to 0.
- Request stage is combinational from the counters: pix_req, pix_x/y, win_req, win_x/y, frame_start, line_start.
- win_req = (hcnt < WIN_W<<SCALE_SHIFT) && (vcnt < WIN_H<<SCALE_SHIFT) && pix_req. If the window exceeds the display, it is clipped by pix_req.
- Raw sync decode:
  - hs_raw is active for hcnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vs_raw is active for vcnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
  - Both are whole-line aligned to hcnt.
- hs_raw, vs_raw and pix_req pass through a PIPE_LAT-deep shift register, then one output register.
  - Output polarity is applied at the output register: hsync = HS_POL when active, else ~HS_POL; vsync uses VS_POL the same way.
  - rgb register captures pix_data only when the delayed DE is high; otherwise it loads 0.
- PIPE_LAT = 0 degenerates to the single output register.
- Reset values:
  - hcnt and vcnt = 0; the shift register is cleared to inactive.
  - hsync = ~HS_POL, vsync = ~VS_POL, de = 0, rgb = 0.
  - Request-stage outputs follow the counters, so the first cycle after reset shows position (0,0), with frame_start = 1.
- Reset mid-frame: counters and pipeline clear on the next edge. No partial sync pulse is emitted after reset; outputs sit inactive until the shifted data arrives.

## Timing
- Request for position (x,y) is presented in cycle t. The matching hsync/vsync/de/rgb appear at output in cycle t+PIPE_LAT+1.
- hsync low width = H_SYNC clocks; vsync low width = V_SYNC x H_TOTAL clocks (default polarity).
- Frame period = H_TOTAL x V_TOTAL = 420000 clocks at default.
- de is high for exactly H_DISPLAY consecutive clocks on each of V_DISPLAY lines per frame.
- frame_start and line_start coincide at (0,0).
- Counter width is 11 bits, so H_TOTAL and V_TOTAL must each be ≤ 2048. Illegal parameters are an elaboration-time assertion.

## Test plan
- Reset, then run 2 frames at defaults:
  - frame_start period = 420000 clocks.
  - hsync low for 96 clocks, starting at output cycle 656+3 of each line.
  - vsync low for 1600 clocks.
- pix_data = {pix_y[4:0], pix_x[10:0]} delayed by a 2-clock model: rgb at every de cycle equals the value encoding its own (x,y). No off-by-one at x=0/639 or y=0/479.
- Sweep PIPE_LAT = 0, 3, 7: the first de rise after frame_start occurs PIPE_LAT+1 clocks after (0,0) request, and rgb alignment holds.
- Window at defaults:
  - win_req high for x 0..639, y 0..479 (the full display).
  - win_x = 39 at hcnt 156..159; win_y = 119 at vcnt 476..479.
- Window clipping with WIN_W=200, SCALE_SHIFT=2: win_req falls at hcnt=640, and win_x never exceeds 159.
- Assert sys_rst at hcnt=700, vcnt=491 (mid-vsync), for one clock:
  - next cycle: vsync = hsync = 1, de = 0, rgb = 0, frame_start = 1.
  - the following frame timing matches the first test.
